// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store request into one word-wide bus
// access with byte enables, extends load data, and stalls the core until done.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for mem_read/mem_write; checks legality, latches bus fields
// REQ    | bus_req held high until bus_ready or the wait counter expires
// DONE   | one cycle: stall released, fault/error pulse valid, back to IDLE
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        stall,
  output logic [31:0] r_data,
  output logic        access_fault,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Wait counter only needs to reach TIMEOUT-1; TIMEOUT=0 turns expiry off.
  localparam int            CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int            TC_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TC    = TC_I[CW-1:0];
  localparam logic          TO_EN = (TIMEOUT != 0);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_lo;

  logic          req_any;
  logic          fault;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext_data;

  assign req_any = mem_read | mem_write;

  // Legality of the incoming request: width vs. alignment, funct3 encoding,
  // and simultaneous read/write.
  always_comb begin
    fault = 1'b0;
    if (mem_read && mem_write) begin
      fault = 1'b1;
    end else if (mem_read) begin
      case (func3)
        3'b000, 3'b100: fault = 1'b0;
        3'b001, 3'b101: fault = addr[0];
        3'b010:         fault = |addr[1:0];
        default:        fault = 1'b1;
      endcase
    end else if (mem_write) begin
      case (func3)
        3'b000:  fault = 1'b0;
        3'b001:  fault = addr[0];
        3'b010:  fault = |addr[1:0];
        default: fault = 1'b1;
      endcase
    end
  end

  // Byte enables and lane-replicated store data; func3[1:0] gives the width
  // for both loads and stores.
  always_comb begin
    be_next    = 4'hF;
    wdata_next = w_data;
    case (func3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{w_data[7:0]}};
      end
      2'b01: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{w_data[15:0]}};
      end
      default: begin
        be_next    = 4'hF;
        wdata_next = w_data;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (ld_lo)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = ld_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_f3)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = bus_rdata;
    endcase
  end

  // Stall is combinational so the core freezes in the same cycle it asks.
  always_comb begin
    case (state)
      S_IDLE:  stall = req_any;
      S_REQ:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Sequencer, bus registers, wait counter, load result and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      ld_f3        <= 3'b000;
      ld_lo        <= 2'b00;
      r_data       <= 32'h0;
      access_fault <= 1'b0;
      bus_error    <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_be       <= 4'h0;
      bus_wdata    <= 32'h0;
    end else begin
      access_fault <= 1'b0;
      bus_error    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            if (fault) begin
              access_fault <= 1'b1;
              state        <= S_DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= mem_write ? wdata_next : 32'h0;
              ld_f3     <= func3;
              ld_lo     <= addr[1:0];
              wait_cnt  <= '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= S_DONE;
            if (!bus_we) r_data <= ext_data;
          end else if (TO_EN && (wait_cnt == TC)) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            r_data    <= 32'h0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
